step_sequencer: RTL and testbench
=================================

# step_sequencer

Upstream control stage for the LED pattern display. It debounces the start key and divides the 50 MHz board clock down to the step rate. A run/hold/pause state machine then produces the current pattern step index (1..NUM_STEPS) and a completed-pass counter in binary and BCD. The pattern translator consumes `step_index`, and the seven-segment decoders consume the BCD digits.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency
- STEP_HZ, 10, step tick rate; TICK_DIV = CLK_HZ/STEP_HZ
- NUM_STEPS, 45, last step index before wrap to 1
- HOLD_STEP_A, 12, first dwell step
- HOLD_STEP_B, 32, second dwell step
- HOLD_TICKS, 10, extra ticks spent on a dwell step
- DEBOUNCE_CYCLES, 500_000, stable-level cycles required on the key

Ports:
- clk_50mhz  in  1  sole clock
- key_zero_reset  in  1  asynchronous, active-low reset
- key_one_start  in  1  raw active-low push button, asynchronous to clock
- running  out  1  high in RUN or HOLD
- step_index  out  6  current step; 0 = idle/blank
- step_strobe  out  1  one-cycle pulse on the cycle step_index changes
- repeat_count  out  5  completed passes, wraps 31→0
- repeat_tens  out  4  BCD tens of repeat_count (0..3)
- repeat_ones  out  4  BCD ones of repeat_count (0..9)

## Operation
- Key path: 2-flop synchronizer, then debounce counter. The debounced level updates after DEBOUNCE_CYCLES consecutive identical synchronized samples. A press event is a one-cycle pulse on a debounced 1→0 transition.
- States: IDLE, RUN, HOLD, PAUSE. Reset enters IDLE.
- IDLE + press → RUN. step_index←1, strobe pulses, prescaler←0.
- RUN + tick:
  - If step_index==NUM_STEPS: step_index←1, repeat_count+1, BCD+1.
  - Else if step_index ∈ {HOLD_STEP_A, HOLD_STEP_B}: → HOLD, hold_cnt←0, step unchanged, no strobe.
  - Else: step_index+1.
- HOLD + tick:
  - hold_cnt+1.
  - When hold_cnt==HOLD_TICKS-1 at the tick: step_index+1, → RUN.
  - A dwell step is therefore shown for HOLD_TICKS+1 ticks.
- RUN/HOLD + press → PAUSE. The previous state is remembered, and step_index, hold_cnt and repeat values are frozen.
- PAUSE + press → remembered state. The prescaler resumes from its frozen value.
- The prescaler counts only in RUN/HOLD. The tick is asserted when prescaler==TICK_DIV-1, and the prescaler wraps to 0 on that cycle.
- BCD counters increment in lockstep with repeat_count. ones 9→0 carries into tens; 31→00 wraps all three together.

## Timing
- Reset values: running=0, step_index=0, step_strobe=0, repeat_count=0, repeat_tens=0, repeat_ones=0, state IDLE, prescaler=0, debounced level=1.
- Reset is asynchronous: asserting key_zero_reset mid-run clears all outputs immediately, with no clock needed. Release is synchronous to the next clk_50mhz edge.
- Press latency: key low → running high is 2 + DEBOUNCE_CYCLES + 1 cycles.
- First tick occurs TICK_DIV cycles after RUN entry. All outputs are registered, and step_index updates on the tick edge.
- Press and tick in the same cycle: the press wins, the tick is discarded, and the prescaler wraps to 0 then freezes.
- A tick on the wrap step with NUM_STEPS equal to a hold step: the wrap rule takes precedence.
- Key bounce shorter than DEBOUNCE_CYCLES produces no event. Holding the key produces exactly one event.

## Structure
- Package step_seq_pkg holds the state encoding (IDLE, RUN, HOLD, PAUSE) and the widths of step_index and repeat_count.
- Sub-module key_debouncer contains the synchronizer, debounce counter and falling-edge press pulse, parameterised by DEBOUNCE_CYCLES.
- The prescaler, FSM, step counter and BCD counter live in step_sequencer.

## Test plan
The bench uses CLK_HZ=100, STEP_HZ=10, DEBOUNCE_CYCLES=4.
- Reset then press: key low for 8 cycles → running=1 and step_index=1 at cycle 7 with strobe; step 2 follows 10 cycles later.
- Dwell: run from step 11 → step 12 shown for 110 cycles (11 ticks), then 13; likewise step 32.
- Wrap: at step 45, tick → step_index=1, repeat_count 0→1, ones=1. Preload 9 passes → next wrap gives tens=1, ones=0. At 31 passes, next wrap → 0/0/0.
- Pause/resume: press at step 20 mid-prescale (count 6) → outputs frozen 200 cycles; press again → step 21 arrives 4 cycles after resume, running=1.
- Bounce: key toggles every 2 cycles for 20 cycles → no state change. Press coincident with tick in RUN → PAUSE and step unchanged.
- Async reset mid-HOLD: assert key_zero_reset between clock edges → all outputs 0 before the next edge, and IDLE after release.

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared types and widths for the step sequencer and its key front end.
package step_seq_pkg;

  localparam int unsigned StepW = 6;
  localparam int unsigned RepW  = 5;
  localparam int unsigned BcdW  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StHold  = 2'd2,
    StPause = 2'd3
  } state_e;

  // RUN and HOLD are the only states in which the display advances.
  function automatic logic is_active(state_e s);
    return (s == StRun) || (s == StHold);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Start key front end: 2-flop synchronizer, stable-level debounce counter, and a
// one-cycle press pulse on each debounced high-to-low transition.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // Count consecutive synchronized samples that disagree with the debounced level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = sync_q[1];
      cnt_d   = '0;
      press_d = ~sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer and debounce state; the idle key level is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_ni};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: tick prescaler, IDLE/RUN/HOLD/PAUSE control, step index with
// dwell steps, and a completed-pass counter kept in binary and BCD.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned STEP_HZ         = 10,
  parameter int unsigned NUM_STEPS       = 45,
  parameter int unsigned HOLD_STEP_A     = 12,
  parameter int unsigned HOLD_STEP_B     = 32,
  parameter int unsigned HOLD_TICKS      = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic             clk_50mhz,
  input  logic             key_zero_reset,
  input  logic             key_one_start,
  output logic             running,
  output logic [StepW-1:0] step_index,
  output logic             step_strobe,
  output logic [RepW-1:0]  repeat_count,
  output logic [BcdW-1:0]  repeat_tens,
  output logic [BcdW-1:0]  repeat_ones
);

  localparam int unsigned TickDiv = CLK_HZ / STEP_HZ;
  localparam int unsigned PrescW  = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned HoldW   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PrescW-1:0] PrescLast = PrescW'(TickDiv - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_TICKS - 1);
  localparam logic [StepW-1:0]  StepLast  = StepW'(NUM_STEPS);
  localparam logic [StepW-1:0]  StepA     = StepW'(HOLD_STEP_A);
  localparam logic [StepW-1:0]  StepB     = StepW'(HOLD_STEP_B);

  state_e             state_q, state_d;
  state_e             resume_q, resume_d;
  logic [PrescW-1:0]  presc_q, presc_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [StepW-1:0]   step_q, step_d;
  logic               strobe_q, strobe_d;
  logic [RepW-1:0]    rep_q, rep_d;
  logic [BcdW-1:0]    tens_q, tens_d;
  logic [BcdW-1:0]    ones_q, ones_d;
  logic               press;
  logic               active;
  logic               tick;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk_i  (clk_50mhz),
    .rst_ni (key_zero_reset),
    .key_ni (key_one_start),
    .press_o(press)
  );

  assign active = is_active(state_q);
  assign tick   = active && (presc_q == PrescLast);

  // Next-state logic for the FSM, prescaler, step and pass counters.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    presc_d  = presc_q;
    hold_d   = hold_q;
    step_d   = step_q;
    strobe_d = 1'b0;
    rep_d    = rep_q;
    tens_d   = tens_q;
    ones_d   = ones_q;

    // A press on the terminal count still wraps the prescaler; otherwise it freezes.
    if (active) begin
      if (tick) begin
        presc_d = '0;
      end else if (!press) begin
        presc_d = presc_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d  = StRun;
          step_d   = StepW'(1);
          strobe_d = 1'b1;
          presc_d  = '0;
        end
      end
      StRun: begin
        if (press) begin
          state_d  = StPause;
          resume_d = StRun;
        end else if (tick) begin
          // Wrap is checked first so a dwell step that is also the last step wraps.
          if (step_q == StepLast) begin
            step_d   = StepW'(1);
            strobe_d = 1'b1;
            if (rep_q == '1) begin
              rep_d  = '0;
              tens_d = '0;
              ones_d = '0;
            end else begin
              rep_d = rep_q + 1'b1;
              if (ones_q == BcdW'(9)) begin
                ones_d = '0;
                tens_d = tens_q + 1'b1;
              end else begin
                ones_d = ones_q + 1'b1;
              end
            end
          end else if ((step_q == StepA) || (step_q == StepB)) begin
            state_d = StHold;
            hold_d  = '0;
          end else begin
            step_d   = step_q + 1'b1;
            strobe_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (press) begin
          state_d  = StPause;
          resume_d = StHold;
        end else if (tick) begin
          if (hold_q == HoldLast) begin
            state_d  = StRun;
            step_d   = step_q + 1'b1;
            strobe_d = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      StPause: begin
        if (press) begin
          state_d = resume_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_50mhz or negedge key_zero_reset) begin
    if (!key_zero_reset) begin
      state_q  <= StIdle;
      resume_q <= StRun;
      presc_q  <= '0;
      hold_q   <= '0;
      step_q   <= '0;
      strobe_q <= 1'b0;
      rep_q    <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
      strobe_q <= strobe_d;
      rep_q    <= rep_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
    end
  end

  assign running      = active;
  assign step_index   = step_q;
  assign step_strobe  = strobe_q;
  assign repeat_count = rep_q;
  assign repeat_tens  = tens_q;
  assign repeat_ones  = ones_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer with a pass-position reference model.
module tb_step_sequencer;

  localparam int CLK_HZ     = 100;
  localparam int STEP_HZ    = 10;
  localparam int DEB        = 4;
  localparam int NUM_STEPS  = 45;
  localparam int HOLD_A     = 12;
  localparam int HOLD_B     = 32;
  localparam int HOLD_TICKS = 10;
  localparam int TICK_DIV   = CLK_HZ / STEP_HZ;
  localparam int HIST_LEN   = DEB + 2;

  logic       clk = 1'b0;
  logic       key_zero_reset;
  logic       key_one_start;
  logic       running;
  logic [5:0] step_index;
  logic       step_strobe;
  logic [4:0] repeat_count;
  logic [3:0] repeat_tens;
  logic [3:0] repeat_ones;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  step_sequencer #(
    .CLK_HZ         (CLK_HZ),
    .STEP_HZ        (STEP_HZ),
    .NUM_STEPS      (NUM_STEPS),
    .HOLD_STEP_A    (HOLD_A),
    .HOLD_STEP_B    (HOLD_B),
    .HOLD_TICKS     (HOLD_TICKS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_50mhz     (clk),
    .key_zero_reset(key_zero_reset),
    .key_one_start (key_one_start),
    .running       (running),
    .step_index    (step_index),
    .step_strobe   (step_strobe),
    .repeat_count  (repeat_count),
    .repeat_tens   (repeat_tens),
    .repeat_ones   (repeat_ones)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Number of ticks a step stays on screen within one pass.
  function automatic int dwell_of(input int s);
    if (s != NUM_STEPS && (s == HOLD_A || s == HOLD_B)) return HOLD_TICKS + 1;
    return 1;
  endfunction

  function automatic int pass_len();
    int total;
    total = 0;
    for (int s = 1; s <= NUM_STEPS; s++) total += dwell_of(s);
    return total;
  endfunction

  // Step shown at tick position p within a pass.
  function automatic int step_of(input int p);
    int left;
    int found;
    left  = p;
    found = 0;
    for (int s = 1; s <= NUM_STEPS; s++) begin
      if (found == 0) begin
        if (left < dwell_of(s)) found = s;
        else left -= dwell_of(s);
      end
    end
    return found;
  endfunction

  // Reference model: mode 0 idle, 1 advancing, 2 paused; p = tick position in pass.
  int m_mode, m_p, m_presc, m_passes, m_step;
  bit m_strobe, m_level, m_press;
  bit hist[HIST_LEN];

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_presc = 0; m_passes = 0; m_step = 0;
    m_strobe = 0; m_level = 1; m_press = 0;
    for (int i = 0; i < HIST_LEN; i++) hist[i] = 1'b1;
  endtask

  task automatic model_step();
    int old_step;
    bit all_diff;
    for (int i = HIST_LEN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0]  = key_one_start;
    old_step = m_step;
    if (m_press) begin
      if (m_mode == 0) begin
        m_mode = 1; m_p = 0; m_presc = 0;
      end else if (m_mode == 1) begin
        if (m_presc == TICK_DIV - 1) m_presc = 0;
        m_mode = 2;
      end else begin
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (m_presc == TICK_DIV - 1) begin
        m_presc = 0;
        m_p++;
        if (m_p == pass_len()) begin
          m_p = 0;
          m_passes = (m_passes + 1) % 32;
        end
      end else begin
        m_presc++;
      end
    end
    m_step   = (m_mode == 0) ? 0 : step_of(m_p);
    m_strobe = (m_step != old_step);
    // Debounced level flips once DEB synchronized samples in a row disagree with it.
    all_diff = 1'b1;
    for (int i = 2; i < HIST_LEN; i++) if (hist[i] == m_level) all_diff = 1'b0;
    m_press = all_diff && m_level;
    if (all_diff) m_level = ~m_level;
  endtask

  always @(posedge clk or negedge key_zero_reset) begin
    if (!key_zero_reset) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("running", int'(running), int'(m_mode == 1));
      check("step_index", int'(step_index), m_step);
      check("step_strobe", int'(step_strobe), int'(m_strobe));
      check("repeat_count", int'(repeat_count), m_passes);
      check("repeat_tens", int'(repeat_tens), m_passes / 10);
      check("repeat_ones", int'(repeat_ones), m_passes % 10);
    end
  end

  task automatic wait_step(input int s, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(int'(step_index) == s && step_strobe) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(int'(step_index) == s && step_strobe), 1);
  endtask

  task automatic wait_rep(input int r, input int budget, input string name);
    int n;
    n = 0;
    while (int'(repeat_count) != r && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(repeat_count), r);
  endtask

  task automatic measure_dwell(input int s, input string name);
    int cnt;
    cnt = 1;
    @(negedge clk);
    while (int'(step_index) == s && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check(name, cnt, (HOLD_TICKS + 1) * TICK_DIV);
    check({name, "_next"}, int'(step_index), s + 1);
  endtask

  initial begin
    key_zero_reset = 1'b0;
    key_one_start  = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("pass_len", pass_len(), 65);
    check("step_of_dwell", step_of(21), 12);
    check("reset_step", int'(step_index), 0);
    check("reset_running", int'(running), 0);
    #2 key_zero_reset = 1'b1;

    // Press: running and step 1 exactly 7 cycles after the key goes low.
    repeat (2) @(negedge clk);
    key_one_start = 1'b0;
    repeat (6) @(negedge clk);
    check("press_early", int'(running), 0);
    @(negedge clk);
    check("press_running", int'(running), 1);
    check("press_step", int'(step_index), 1);
    check("press_strobe", int'(step_strobe), 1);
    @(negedge clk);
    key_one_start = 1'b1;
    repeat (8) @(negedge clk);
    check("step1_hold", int'(step_index), 1);
    @(negedge clk);
    check("step2_arrive", int'(step_index), 2);
    check("step2_strobe", int'(step_strobe), 1);

    // Dwell steps.
    wait_step(12, 200, "reach_12");
    measure_dwell(12, "dwell_12");
    wait_step(32, 300, "reach_32");
    measure_dwell(32, "dwell_32");

    // Wrap and BCD carry.
    wait_step(1, 400, "wrap_1");
    check("wrap1_count", int'(repeat_count), 1);
    check("wrap1_ones", int'(repeat_ones), 1);
    check("wrap1_tens", int'(repeat_tens), 0);
    wait_rep(9, 9 * 700, "reach_9");
    wait_step(1, 700, "wrap_10");
    check("wrap10_count", int'(repeat_count), 10);
    check("wrap10_tens", int'(repeat_tens), 1);
    check("wrap10_ones", int'(repeat_ones), 0);
    wait_rep(31, 22 * 700, "reach_31");
    wait_step(1, 700, "wrap_32");
    check("wrap0_count", int'(repeat_count), 0);
    check("wrap0_tens", int'(repeat_tens), 0);
    check("wrap0_ones", int'(repeat_ones), 0);

    // Pause at step 20 with the prescaler at 6, then resume.
    wait_step(20, 700, "reach_20");
    key_one_start = 1'b0;
    repeat (7) @(negedge clk);
    check("pause_running", int'(running), 0);
    check("pause_step", int'(step_index), 20);
    @(negedge clk);
    key_one_start = 1'b1;
    repeat (200) @(negedge clk);
    check("frozen_step", int'(step_index), 20);
    check("frozen_running", int'(running), 0);
    key_one_start = 1'b0;
    repeat (7) @(negedge clk);
    check("resume_running", int'(running), 1);
    check("resume_step", int'(step_index), 20);
    @(negedge clk);
    key_one_start = 1'b1;
    repeat (2) @(negedge clk);
    check("resume_wait", int'(step_index), 20);
    @(negedge clk);
    check("resume_step21", int'(step_index), 21);
    check("resume_strobe", int'(step_strobe), 1);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 10; i++) begin
      key_one_start = (i % 2 == 1);
      repeat (2) @(negedge clk);
    end
    key_one_start = 1'b1;
    repeat (8) @(negedge clk);
    check("bounce_running", int'(running), 1);

    // Press coincident with a tick: pause wins, prescaler restarts from 0.
    wait_step(5, 700, "reach_5");
    repeat (3) @(negedge clk);
    key_one_start = 1'b0;
    repeat (7) @(negedge clk);
    check("coinc_running", int'(running), 0);
    check("coinc_step", int'(step_index), 5);
    check("coinc_strobe", int'(step_strobe), 0);
    @(negedge clk);
    key_one_start = 1'b1;
    repeat (20) @(negedge clk);
    key_one_start = 1'b0;
    repeat (7) @(negedge clk);
    check("coinc_resume", int'(running), 1);
    @(negedge clk);
    key_one_start = 1'b1;
    repeat (8) @(negedge clk);
    check("coinc_wait", int'(step_index), 5);
    @(negedge clk);
    check("coinc_step6", int'(step_index), 6);

    // Asynchronous reset in the middle of a dwell.
    wait_step(12, 700, "reach_12b");
    repeat (30) @(negedge clk);
    #2 key_zero_reset = 1'b0;
    #1;
    check("areset_running", int'(running), 0);
    check("areset_step", int'(step_index), 0);
    check("areset_strobe", int'(step_strobe), 0);
    check("areset_count", int'(repeat_count), 0);
    check("areset_tens", int'(repeat_tens), 0);
    check("areset_ones", int'(repeat_ones), 0);
    @(negedge clk);
    #2 key_zero_reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_running", int'(running), 0);
    check("idle_step", int'(step_index), 0);

    // Randomized key activity with occasional resets.
    for (int k = 0; k < 300; k++) begin
      key_one_start = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) begin
        #2 key_zero_reset = 1'b0;
        @(negedge clk);
        #2 key_zero_reset = 1'b1;
      end
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    key_one_start = 1'b1;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
